// File: rtl/rf_sb_if.sv
// Register-file bus: read/write/reserve ports of rf_sb, grouped for decode and writeback.
// master = decode/writeback side, slave = the register file.
interface rf_sb_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 3
);
   logic [AW-1:0]    readReg1Sel;
   logic [AW-1:0]    readReg2Sel;
   logic [AW-1:0]    writeRegSel;
   logic [WIDTH-1:0] writeData;
   logic             writeEn;
   logic [AW-1:0]    resvRegSel;
   logic             resvEn;
   logic [WIDTH-1:0] readData1;
   logic [WIDTH-1:0] readData2;
   logic             readBusy1;
   logic             readBusy2;
   logic             err;

   modport master (
      output readReg1Sel, readReg2Sel, writeRegSel, writeData, writeEn,
             resvRegSel, resvEn,
      input  readData1, readData2, readBusy1, readBusy2, err
   );

   modport slave (
      input  readReg1Sel, readReg2Sel, writeRegSel, writeData, writeEn,
             resvRegSel, resvEn,
      output readData1, readData2, readBusy1, readBusy2, err
   );
endinterface

// File: rtl/rf_sb.sv
// Register file with a 2-bit outstanding-writer counter per register for RAW hazard detection.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module rf_sb #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic   clk,
   input  logic   rst,
   rf_sb_if.slave bus
);
   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [1:0]       cnt_q  [DEPTH];
   logic [1:0]       cnt_d  [DEPTH];
   logic [DEPTH-1:0] wr_hit;
   logic [DEPTH-1:0] rs_hit;
   logic [DEPTH-1:0] ovf;
   logic             in_unknown;
   logic [WIDTH-1:0] data1, data2;
   logic             busy1, busy2;

   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         wr_hit[r] = bus.writeEn && (bus.writeRegSel == AW'(r));
         rs_hit[r] = bus.resvEn  && (bus.resvRegSel  == AW'(r));
      end
   end

   // A reserve and a write to the same register cancel out, even at 0 or 3.
   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         cnt_d[r] = cnt_q[r];
         ovf[r]   = 1'b0;
         if (rs_hit[r] && wr_hit[r]) begin
            cnt_d[r] = cnt_q[r];
         end else if (rs_hit[r]) begin
            if (cnt_q[r] == 2'd3) begin
               ovf[r] = 1'b1;
            end else begin
               cnt_d[r] = cnt_q[r] + 2'd1;
            end
         end else if (wr_hit[r] && (cnt_q[r] != 2'd0)) begin
            cnt_d[r] = cnt_q[r] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
      end else begin
         if (bus.writeEn) begin
            regs_q[bus.writeRegSel] <= bus.writeData;
         end
         for (int r = 0; r < DEPTH; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   // Forwarded busy reflects the count after the retiring write, never a same-cycle reserve.
   always_comb begin
      data1 = regs_q[bus.readReg1Sel];
      busy1 = (cnt_q[bus.readReg1Sel] != 2'd0);
      data2 = regs_q[bus.readReg2Sel];
      busy2 = (cnt_q[bus.readReg2Sel] != 2'd0);
`ifdef RF_BYPASS_EN
      if (bus.writeEn && (bus.readReg1Sel == bus.writeRegSel)) begin
         data1 = bus.writeData;
         busy1 = (cnt_q[bus.readReg1Sel] > 2'd1);
      end
      if (bus.writeEn && (bus.readReg2Sel == bus.writeRegSel)) begin
         data2 = bus.writeData;
         busy2 = (cnt_q[bus.readReg2Sel] > 2'd1);
      end
`endif
   end

   assign in_unknown = $isunknown({bus.readReg1Sel, bus.readReg2Sel, bus.writeRegSel,
                                   bus.writeData, bus.writeEn, bus.resvRegSel, bus.resvEn});

   assign bus.readData1 = rst ? '0 : data1;
   assign bus.readData2 = rst ? '0 : data2;
   assign bus.readBusy1 = rst ? 1'b0 : busy1;
   assign bus.readBusy2 = rst ? 1'b0 : busy2;
   assign bus.err       = !rst && (in_unknown || (|ovf));
endmodule

// File: doc/rf_sb.md
# rf_sb

Parametrised register file with per-register scoreboard for the pipelined datapath. It provides one synchronous write port and two combinational read ports, with configurable width and depth. Each register has a 2-bit outstanding-writer counter, so decode can detect RAW hazards without a separate hazard table. Sits in decode, replacing the fixed 8x16 register file; writeback drives the write port, decode drives reserve.

## Interface
- WIDTH, 16, data bits per register
- DEPTH, 8, number of registers; must be a power of two, at least 2
- AW, $clog2(DEPTH), select width (derived; do not override)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- readReg1Sel  input  AW  read port 1 select
- readReg2Sel  input  AW  read port 2 select
- writeRegSel  input  AW  write select
- writeData  input  WIDTH  write data
- writeEn  input  1  write strobe; also retires one outstanding writer
- resvRegSel  input  AW  reserve select (destination of newly issued instruction)
- resvEn  input  1  reserve strobe; adds one outstanding writer
- readData1  output  WIDTH  contents of readReg1Sel
- readData2  output  WIDTH  contents of readReg2Sel
- readBusy1  output  1  register readReg1Sel has an outstanding writer
- readBusy2  output  1  register readReg2Sel has an outstanding writer
- err  output  1  combinational error flag

## Operation
- State:
  - regs[DEPTH] of WIDTH bits.
  - cnt[DEPTH] of 2 bits (outstanding writers, 0..3).
- Write: on the edge, if writeEn, regs[writeRegSel] <= writeData.
- Counter update per register r, on each edge:
  - +1 if resvEn and resvRegSel==r.
  - -1 if writeEn and writeRegSel==r and cnt[r]!=0.
  - Both together: no change (net 0).
  - Write at cnt 0: data is written, counter stays 0 (untracked write; legal).
  - Reserve at cnt 3 without a same-register write: counter holds 3 and err is asserted that cycle.
- Read:
  - readDataN = regs[readRegNSel] (combinational).
  - readBusyN = (cnt[readRegNSel]!=0).
  - Both reads are subject to bypass (see Configuration).
- err is asserted, combinationally, when any of the following holds:
  - Any input is X/Z while rst is low.
  - Counter overflow attempt as defined above.
- Reset: all regs and cnt clear to 0 immediately (asynchronous).
  - While rst is high: readData1/2=0, readBusy1/2=0, err=0.
  - Writes and reserves are ignored.

## Timing
- Read latency: 0 cycles (combinational from selects and state).
- Write visibility: the next cycle without bypass; the same cycle with bypass.
- Busy clears the cycle after the retiring write edge; with bypass, as soon as the retiring write is presented.
- Reserve visibility: busy asserts the cycle after the resvEn edge. A same-cycle reserve is never bypassed.
- Reset assertion mid-cycle clears outputs without waiting for clk. Deassertion is sampled by the next rising edge; the first write may occur on that edge.
- Simultaneous write to a register and read of it: result depends on RF_BYPASS_EN.
- Simultaneous reserve and write to the same register: the counter is unchanged, data is written.

## Configuration
- RF_BYPASS_EN defined, for a read port N whose readRegNSel equals writeRegSel while writeEn is high:
  - readDataN = writeData in that cycle.
  - readBusyN = (cnt-after-this-write != 0), ignoring any same-cycle reserve.
- RF_BYPASS_EN undefined: no forwarding. Reads return pre-edge state; decode must stall one cycle for write-then-read.

## Test plan
- Reset and initial state:
  - Stimulus: assert rst mid-cycle after writing 0xBEEF to r3.
  - Required: readData1 (sel 3) goes to 0 before the next edge; all busy=0.
- Basic write/read (WIDTH=16, DEPTH=8):
  - Stimulus: write 0x1234 to r5, then read r5 on both ports.
  - Required, next cycle: readData1=readData2=0x1234.
  - Required, write cycle: readData shows 0x1234 with bypass, old value 0x0000 without.
- Scoreboard sequence on r2 (two reserves, two writes on consecutive cycles):
  - Required busy: 1,1,1,0 after each respective edge.
  - Required with bypass: busy reads 0 during the second write cycle.
- Overflow and counter edge cases:
  - Four reserves to r7: err=1 on the fourth, cnt stays 3.
  - Reserve + write to r7 together: cnt unchanged, err=0.
  - Write at cnt 0: data written, busy stays 0.
- Parameter sweep:
  - Configurations: WIDTH=32/DEPTH=16 and WIDTH=8/DEPTH=2.
  - Write a distinct pattern to every register, then read all back.
  - Required: all read back correctly; no err.
